mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
- Two-client read arbiter between the instruction cache, the data cache and the single shared memory read channel.
- Grants one cache at a time, forwards that cache's burst read request, and steers the whole response burst back to it.
- Ownership is held until the beat marked last has been accepted.
- Arbitration is round-robin, so neither cache can starve the other.

Parameters:
ADDR_W, 32, request address width (requests are 32-byte aligned)
DATA_W, 32, width of one response data beat

Ports:
clk  in  1  clock
rst  in  1  reset
ic_rd_req_valid  in  1  I-cache read request valid
ic_rd_req_addr  in  ADDR_W  I-cache request address
ic_rd_req_ready  out  1  arbiter accepted I-cache request
ic_rd_rsp_valid  out  1  beat valid to I-cache
ic_rd_rsp_data  out  DATA_W  beat data to I-cache
ic_rd_rsp_last  out  1  last beat to I-cache
ic_rd_rsp_ready  in  1  I-cache accepts beat
dc_rd_req_valid  in  1  D-cache read request valid
dc_rd_req_addr  in  ADDR_W  D-cache request address
dc_rd_req_ready  out  1  arbiter accepted D-cache request
dc_rd_rsp_valid  out  1  beat valid to D-cache
dc_rd_rsp_data  out  DATA_W  beat data to D-cache
dc_rd_rsp_last  out  1  last beat to D-cache
dc_rd_rsp_ready  in  1  D-cache accepts beat
mem_rd_req_valid  out  1  request valid to memory
mem_rd_req_addr  out  ADDR_W  request address to memory
mem_rd_req_ready  in  1  memory accepts request
mem_rd_rsp_valid  in  1  memory beat valid
mem_rd_rsp_data  in  DATA_W  memory beat data
mem_rd_rsp_last  in  1  memory last beat
mem_rd_rsp_ready  out  1  arbiter accepts beat

Behaviour:
Reset and state:
- Reset rst, synchronous, active-high; clock clk.
- One-hot FSM with states IDLE, REQ, RSP. Registers: owner (0 = I-cache, 1 = D-cache) and prio (0 = I-cache preferred, 1 = D-cache preferred).
- Reset: state = IDLE, owner = 0, prio = 0. All valid/ready outputs are 0 during the cycle after rst is sampled high. Data/addr outputs are don't-care when the matching valid is 0.

IDLE:
- No requester: stay in IDLE.
- One requester: owner <= that client.
- Both requesting: owner <= the client selected by prio.
- Any request: go to REQ.
- Both req_ready outputs and mem_rd_req_valid are 0 in IDLE, so a request reaches memory no earlier than 1 cycle after the client asserts valid.

REQ:
- mem_rd_req_valid = owner's req_valid; mem_rd_req_addr = owner's req_addr.
- Owner's req_ready = mem_rd_req_ready; the other client's req_ready = 0.
- On mem_rd_req_valid & mem_rd_req_ready: go to RSP.
- Clients hold valid/addr stable until ready. Dropping valid early is a protocol violation; behaviour is unspecified.

RSP:
- Owner's rsp_valid/data/last mirror mem_rd_rsp_valid/data/last. mem_rd_rsp_ready = owner's rsp_ready.
- The non-owner's rsp_valid is 0 and its req_ready is 0.
- On mem_rd_rsp_valid & mem_rd_rsp_ready & mem_rd_rsp_last: go to IDLE and set prio <= ~owner, so the other client is preferred next.
- Beats without last keep the FSM in RSP. Beats while the owner's rsp_ready = 0 are stalled, not dropped.

Other rules:
- A request from the non-owner during REQ/RSP stays pending, waits, and is arbitrated in the next IDLE.
- Back-to-back: the minimum turnaround between the last beat of one burst and the next request reaching memory is 1 idle cycle.
- No buffering: data paths are purely combinational muxes selected by owner; only state, owner and prio are registered.
- Reset mid-burst: FSM is forced to IDLE and ownership is abandoned. Memory-side reset is the system's responsibility.

Test Plan:
- Reset: rst high 2 cycles -> every valid/ready output 0, state IDLE; first lone dc request after reset is granted.
- Single I-cache burst: ic req addr 0x0000_1020, mem ready after 3 cycles -> mem_rd_req_addr = 0x0000_1020; 8 beats 0xA0..0xA7 appear on ic_rd_rsp_*; dc_rd_rsp_valid stays 0; ic_rd_rsp_last only on the 8th beat.
- Simultaneous requests after reset: ic 0x100, dc 0x200 in the same cycle -> ic is served first; dc is granted in the IDLE after ic's last beat; memory sees 0x100 then 0x200.
- Round-robin: ic and dc both continuously requesting for 4 bursts -> grant order ic, dc, ic, dc.
- Backpressure: owner drops rsp_ready for 5 cycles mid-burst -> mem_rd_rsp_ready is 0 for those cycles; no beat is lost or duplicated; the 8 words are received in order.
- Reset mid-burst: assert rst after the 3rd beat -> next cycle all outputs 0, state IDLE; a new dc request then completes normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one burst read channel between the I-cache and D-cache.
// Only state, owner and prio are registered; request and response paths are muxes on owner.
module mem_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req_valid,
  input  logic [ADDR_W-1:0] ic_rd_req_addr,
  output logic              ic_rd_req_ready,
  output logic              ic_rd_rsp_valid,
  output logic [DATA_W-1:0] ic_rd_rsp_data,
  output logic              ic_rd_rsp_last,
  input  logic              ic_rd_rsp_ready,
  input  logic              dc_rd_req_valid,
  input  logic [ADDR_W-1:0] dc_rd_req_addr,
  output logic              dc_rd_req_ready,
  output logic              dc_rd_rsp_valid,
  output logic [DATA_W-1:0] dc_rd_rsp_data,
  output logic              dc_rd_rsp_last,
  input  logic              dc_rd_rsp_ready,
  output logic              mem_rd_req_valid,
  output logic [ADDR_W-1:0] mem_rd_req_addr,
  input  logic              mem_rd_req_ready,
  input  logic              mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] mem_rd_rsp_data,
  input  logic              mem_rd_rsp_last,
  output logic              mem_rd_rsp_ready
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RSP  = 3'b100
  } state_t;

  state_t state;
  logic   owner;
  logic   prio;
  logic   in_req;
  logic   in_rsp;
  logic   ic_sel;
  logic   dc_sel;

  assign in_req = (state == REQ);
  assign in_rsp = (state == RSP);
  assign ic_sel = ~owner;
  assign dc_sel = owner;

  assign mem_rd_req_valid = in_req & (owner ? dc_rd_req_valid : ic_rd_req_valid);
  assign mem_rd_req_addr  = owner ? dc_rd_req_addr : ic_rd_req_addr;
  assign ic_rd_req_ready  = in_req & ic_sel & mem_rd_req_ready;
  assign dc_rd_req_ready  = in_req & dc_sel & mem_rd_req_ready;

  // Response steering: the non-owner never sees valid, so a stray beat cannot reach it.
  assign ic_rd_rsp_valid  = in_rsp & ic_sel & mem_rd_rsp_valid;
  assign ic_rd_rsp_data   = mem_rd_rsp_data;
  assign ic_rd_rsp_last   = in_rsp & ic_sel & mem_rd_rsp_last;
  assign dc_rd_rsp_valid  = in_rsp & dc_sel & mem_rd_rsp_valid;
  assign dc_rd_rsp_data   = mem_rd_rsp_data;
  assign dc_rd_rsp_last   = in_rsp & dc_sel & mem_rd_rsp_last;
  assign mem_rd_rsp_ready = in_rsp & (owner ? dc_rd_rsp_ready : ic_rd_rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_rd_req_valid | dc_rd_req_valid) begin
            owner <= (ic_rd_req_valid & dc_rd_req_valid) ? prio : dc_rd_req_valid;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_req_valid & mem_rd_req_ready)
            state <= RSP;
        end
        RSP: begin
          // Hand preference to the other client once the burst is fully delivered.
          if (mem_rd_rsp_valid & mem_rd_rsp_ready & mem_rd_rsp_last) begin
            state <= IDLE;
            prio  <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: stimulus pushes expected addresses/beats into
// queues, a behavioural memory answers requests, and a monitor pops and compares.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd_req_valid, ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_last, ic_rd_rsp_ready;
  logic [31:0] ic_rd_req_addr, ic_rd_rsp_data;
  logic        dc_rd_req_valid, dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_last, dc_rd_rsp_ready;
  logic [31:0] dc_rd_req_addr, dc_rd_rsp_data;
  logic        mem_rd_req_valid, mem_rd_req_ready, mem_rd_rsp_valid, mem_rd_rsp_last, mem_rd_rsp_ready;
  logic [31:0] mem_rd_req_addr, mem_rd_rsp_data;

  mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr), .ic_rd_req_ready(ic_rd_req_ready),
    .ic_rd_rsp_valid(ic_rd_rsp_valid), .ic_rd_rsp_data(ic_rd_rsp_data), .ic_rd_rsp_last(ic_rd_rsp_last),
    .ic_rd_rsp_ready(ic_rd_rsp_ready),
    .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr), .dc_rd_req_ready(dc_rd_req_ready),
    .dc_rd_rsp_valid(dc_rd_rsp_valid), .dc_rd_rsp_data(dc_rd_rsp_data), .dc_rd_rsp_last(dc_rd_rsp_last),
    .dc_rd_rsp_ready(dc_rd_rsp_ready),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr), .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_data(mem_rd_rsp_data), .mem_rd_rsp_last(mem_rd_rsp_last),
    .mem_rd_rsp_ready(mem_rd_rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_ic_q[$];
  beat_t       exp_dc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mem_base[logic [31:0]];

  int total = 0;
  int bad = 0;
  int ic_beat_cnt = 0;
  int dc_beat_cnt = 0;
  int mem_lat = 0;
  int mphase = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input bit c, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (c) exp_dc_q.push_back({base + 32'(i), i == 7});
      else   exp_ic_q.push_back({base + 32'(i), i == 7});
    end
  endtask

  // Asserts a request, holds it until the arbiter accepts it, then drops it.
  task automatic do_req(input bit c, input logic [31:0] a);
    bit hs = 1'b0;
    if (c) begin dc_rd_req_valid = 1'b1; dc_rd_req_addr = a; end
    else   begin ic_rd_req_valid = 1'b1; ic_rd_req_addr = a; end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((c ? dc_rd_req_ready : ic_rd_req_ready) === 1'b1) begin
        hs = 1'b1;
        break;
      end
    end
    tick();
    if (c) dc_rd_req_valid = 1'b0;
    else   ic_rd_req_valid = 1'b0;
    if (!hs) chk(c ? "dc_req_timeout" : "ic_req_timeout", 64'(hs), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (exp_ic_q.size() == 0 && exp_dc_q.size() == 0 && exp_addr_q.size() == 0 && mphase == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(name, 64'(done), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, 64'({ic_rd_req_ready, dc_rd_req_ready, mem_rd_req_valid,
                   ic_rd_rsp_valid, dc_rd_rsp_valid, mem_rd_rsp_ready}), 64'd0);
  endtask

  // Behavioural memory: samples handshakes at negedge, updates drives just after posedge.
  initial begin : memory_model
    logic        rst_s, req_hs_s, req_v_s, rsp_hs_s;
    logic [31:0] addr_s, cur_base;
    int          beat, wait_cnt;
    mem_rd_req_ready = 1'b0; mem_rd_rsp_valid = 1'b0;
    mem_rd_rsp_data = 32'h0; mem_rd_rsp_last = 1'b0;
    beat = 0; wait_cnt = 0; cur_base = 32'h0;
    forever begin
      @(negedge clk);
      rst_s    = rst;
      req_v_s  = mem_rd_req_valid;
      req_hs_s = mem_rd_req_valid & mem_rd_req_ready;
      rsp_hs_s = mem_rd_rsp_valid & mem_rd_rsp_ready;
      addr_s   = mem_rd_req_addr;
      tick();
      if (rst_s !== 1'b0) begin
        mem_rd_req_ready = 1'b0; mem_rd_rsp_valid = 1'b0; mem_rd_rsp_last = 1'b0;
        mphase = 0; beat = 0; wait_cnt = 0;
      end else if (mphase == 0) begin
        if (req_hs_s === 1'b1) begin
          cur_base = mem_base.exists(addr_s) ? mem_base[addr_s] : 32'hDEAD_0000;
          mem_rd_req_ready = 1'b0;
          mphase = 1; beat = 0;
          mem_rd_rsp_valid = 1'b1; mem_rd_rsp_data = cur_base; mem_rd_rsp_last = 1'b0;
        end else if (req_v_s === 1'b1) begin
          if (wait_cnt >= mem_lat) mem_rd_req_ready = 1'b1;
          else wait_cnt++;
        end
      end else if (rsp_hs_s === 1'b1) begin
        beat++;
        if (beat == 8) begin
          mem_rd_rsp_valid = 1'b0; mem_rd_rsp_last = 1'b0;
          mphase = 0; wait_cnt = 0;
        end else begin
          mem_rd_rsp_data = cur_base + 32'(beat);
          mem_rd_rsp_last = (beat == 7);
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] ea;
    beat_t       eb;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (mem_rd_req_valid && mem_rd_req_ready) begin
          if (exp_addr_q.size() == 0) chk("mem_req_unexpected", 64'(mem_rd_req_valid), 64'd0);
          else begin
            ea = exp_addr_q.pop_front();
            chk("mem_req_addr", 64'(mem_rd_req_addr), 64'(ea));
          end
        end
        if (ic_rd_rsp_valid && exp_ic_q.size() == 0) chk("ic_rsp_unexpected", 64'(ic_rd_rsp_valid), 64'd0);
        else if (ic_rd_rsp_valid && ic_rd_rsp_ready) begin
          eb = exp_ic_q.pop_front();
          chk("ic_rsp_data", 64'(ic_rd_rsp_data), 64'(eb.d));
          chk("ic_rsp_last", 64'(ic_rd_rsp_last), 64'(eb.l));
          ic_beat_cnt++;
        end
        if (dc_rd_rsp_valid && exp_dc_q.size() == 0) chk("dc_rsp_unexpected", 64'(dc_rd_rsp_valid), 64'd0);
        else if (dc_rd_rsp_valid && dc_rd_rsp_ready) begin
          eb = exp_dc_q.pop_front();
          chk("dc_rsp_data", 64'(dc_rd_rsp_data), 64'(eb.d));
          chk("dc_rsp_last", 64'(dc_rd_rsp_last), 64'(eb.l));
          dc_beat_cnt++;
        end
      end
    end
  end

  initial begin : stimulus
    bit hit;
    rst = 1'b1;
    ic_rd_req_valid = 1'b0; ic_rd_req_addr = 32'h0; ic_rd_rsp_ready = 1'b1;
    dc_rd_req_valid = 1'b0; dc_rd_req_addr = 32'h0; dc_rd_rsp_ready = 1'b1;
    mem_base[32'h0000_0300] = 32'h0000_00D0;
    mem_base[32'h0000_1020] = 32'h0000_00A0;
    mem_base[32'h0000_0100] = 32'h0000_1100;
    mem_base[32'h0000_0200] = 32'h0000_2200;
    mem_base[32'h0000_0400] = 32'h0000_4400;
    mem_base[32'h0000_0440] = 32'h0000_4440;
    mem_base[32'h0000_0500] = 32'h0000_5500;
    mem_base[32'h0000_0540] = 32'h0000_5540;
    mem_base[32'h0000_0600] = 32'h0000_6600;
    mem_base[32'h0000_0700] = 32'h0000_7700;
    mem_base[32'h0000_0740] = 32'h0000_7740;

    // Reset for two cycles, then a lone D-cache request.
    tick(); tick();
    @(negedge clk);
    chk_idle_outputs("reset_outputs");
    tick();
    rst = 1'b0;
    exp_addr_q.push_back(32'h0000_0300);
    push_burst(1'b1, 32'h0000_00D0, 8);
    do_req(1'b1, 32'h0000_0300);
    wait_drain("drain_first_dc");

    // Single I-cache burst with a slow memory request channel.
    mem_lat = 3;
    exp_addr_q.push_back(32'h0000_1020);
    push_burst(1'b0, 32'h0000_00A0, 8);
    do_req(1'b0, 32'h0000_1020);
    wait_drain("drain_ic_single");
    mem_lat = 0;

    // Fresh reset, then both caches request in the same cycle: I-cache wins.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0200);
    push_burst(1'b0, 32'h0000_1100, 8);
    push_burst(1'b1, 32'h0000_2200, 8);
    fork
      do_req(1'b0, 32'h0000_0100);
      do_req(1'b1, 32'h0000_0200);
    join
    wait_drain("drain_simultaneous");

    // Both caches keep requesting: grants alternate ic, dc, ic, dc.
    exp_addr_q.push_back(32'h0000_0400);
    exp_addr_q.push_back(32'h0000_0500);
    exp_addr_q.push_back(32'h0000_0440);
    exp_addr_q.push_back(32'h0000_0540);
    push_burst(1'b0, 32'h0000_4400, 8);
    push_burst(1'b0, 32'h0000_4440, 8);
    push_burst(1'b1, 32'h0000_5500, 8);
    push_burst(1'b1, 32'h0000_5540, 8);
    fork
      begin do_req(1'b0, 32'h0000_0400); do_req(1'b0, 32'h0000_0440); end
      begin do_req(1'b1, 32'h0000_0500); do_req(1'b1, 32'h0000_0540); end
    join
    wait_drain("drain_round_robin");

    // Owner stalls its response for 5 cycles after the third beat.
    ic_beat_cnt = 0;
    exp_addr_q.push_back(32'h0000_0600);
    push_burst(1'b0, 32'h0000_6600, 8);
    do_req(1'b0, 32'h0000_0600);
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ic_beat_cnt >= 3) begin hit = 1'b1; break; end
    end
    if (!hit) chk("stall_point_timeout", 64'(hit), 64'd1);
    ic_rd_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_mem_rsp_ready", 64'(mem_rd_rsp_ready), 64'd0);
      tick();
    end
    ic_rd_rsp_ready = 1'b1;
    wait_drain("drain_backpressure");
    chk("stall_beat_count", 64'(ic_beat_cnt), 64'd8);

    // Reset in the middle of a D-cache burst, then a clean D-cache burst.
    dc_beat_cnt = 0;
    exp_addr_q.push_back(32'h0000_0700);
    push_burst(1'b1, 32'h0000_7700, 3);
    do_req(1'b1, 32'h0000_0700);
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (dc_beat_cnt >= 3) begin hit = 1'b1; break; end
    end
    if (!hit) chk("midrst_point_timeout", 64'(hit), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst_outputs");
    tick();
    exp_addr_q.push_back(32'h0000_0740);
    push_burst(1'b1, 32'h0000_7740, 8);
    do_req(1'b1, 32'h0000_0740);
    wait_drain("drain_after_midrst");

    chk("ic_queue_left", 64'(exp_ic_q.size()), 64'd0);
    chk("dc_queue_left", 64'(exp_dc_q.size()), 64'd0);
    chk("addr_queue_left", 64'(exp_addr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
